// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder sequencer: drives an external 4-bit adder slice one nibble per clock,
// LSB nibble first, and carries between nibbles through an internal flop.
module nibble_serial_add_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   cin,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_ci,
   input  logic [3:0]             add_s,
   input  logic                   add_co,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             cin_q, cin_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_ci  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = op_a;
               b_d     = op_b;
               cin_d   = cin;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Constant-index nibble mux keeps the slice select free of out-of-range reads.
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  add_a                = a_q[4*i +: 4];
                  add_b                = b_q[4*i +: 4];
                  add_ci               = (i == 0) ? cin_q : carry_q;
                  sum_d[4*i +: 4]      = add_s;
               end
            end
            carry_d = add_co;
            if (idx_q == LAST_IDX) begin
               cout_d  = add_co;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl: a 4-nibble and a 1-nibble instance,
// each wired to a behavioural 4-bit adder slice.
module tb_nibble_serial_add_ctrl;

   logic        clk;
   logic        rst_n;

   logic        start;
   logic [15:0] op_a, op_b;
   logic        cin;
   logic [3:0]  add_a, add_b, add_s;
   logic        add_ci, add_co;
   logic        busy, done, cout;
   logic [15:0] sum;

   logic        start1;
   logic [3:0]  op_a1, op_b1;
   logic        cin1;
   logic [3:0]  add_a1, add_b1, add_s1;
   logic        add_ci1, add_co1;
   logic        busy1, done1, cout1;
   logic [3:0]  sum1;

   int checks;
   int failures;

   assign {add_co, add_s}   = 5'(add_a)  + 5'(add_b)  + 5'(add_ci);
   assign {add_co1, add_s1} = 5'(add_a1) + 5'(add_b1) + 5'(add_ci1);

   nibble_serial_add_ctrl #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
      .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
      .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1), .add_s(add_s1), .add_co(add_co1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one operation on the 4-nibble instance and observes it at every falling edge.
   // k counts rising edges after the start edge; done is expected at k == 4.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output int done_k, output int done_cnt, output int busy_cnt,
                        output logic [15:0] ci_trace, output bit timed_out);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; cin = ci;
      @(negedge clk);
      start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; cin = ~ci;
      done_k = -1; done_cnt = 0; busy_cnt = 0; ci_trace = '0; timed_out = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) @(negedge clk);
         ci_trace[k] = add_ci;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
      $display("op a=%h b=%h cin=%b -> sum=%h cout=%b done_k=%0d busy_cycles=%0d",
               a, b, ci, sum, cout, done_k, busy_cnt);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
      start1 = 1'b0; op_a1 = '0; op_b1 = '0; cin1 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, sum, cout} !== 19'h0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b sum=%h cout=%b exp all zero", busy, done, sum, cout);
      end
      checks++;
      if ({add_a, add_b, add_ci} !== 9'h0) begin
         failures++;
         $display("FAIL reset_add_ports got a=%h b=%h ci=%b exp zero", add_a, add_b, add_ci);
      end
      checks++;
      if ({busy1, done1, sum1, cout1} !== 7'h0) begin
         failures++;
         $display("FAIL reset_outputs_n1 got busy=%b done=%b sum=%h cout=%b exp all zero", busy1, done1, sum1, cout1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_carry_ripple();
      int dk, dc, bc; logic [15:0] ct; bit to;
      do_op(16'hFFFF, 16'h0001, 1'b0, dk, dc, bc, ct, to);
      checks++;
      if (to !== 1'b0) begin failures++; $display("FAIL ripple_timeout got=%b exp=0", to); end
      checks++;
      if (sum !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h exp=0000", sum); end
      checks++;
      if (cout !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b exp=1", cout); end
      checks++;
      if (dk !== 4) begin failures++; $display("FAIL ripple_done_cycle got=%0d exp=4", dk); end
      checks++;
      if (dc !== 1) begin failures++; $display("FAIL ripple_done_width got=%0d exp=1", dc); end
   endtask

   task automatic test_no_carry();
      int dk, dc, bc; logic [15:0] ct; bit to;
      do_op(16'h1234, 16'h4321, 1'b0, dk, dc, bc, ct, to);
      checks++;
      if ({cout, sum} !== 17'h05555) begin failures++; $display("FAIL nocarry_result got=%b_%h exp=0_5555", cout, sum); end
      checks++;
      if (bc !== 5) begin failures++; $display("FAIL nocarry_busy_cycles got=%0d exp=5", bc); end
      checks++;
      if (to !== 1'b0) begin failures++; $display("FAIL nocarry_timeout got=%b exp=0", to); end
   endtask

   task automatic test_cin_path();
      int dk, dc, bc; logic [15:0] ct; bit to;
      do_op(16'h000F, 16'h0000, 1'b1, dk, dc, bc, ct, to);
      checks++;
      if ({cout, sum} !== 17'h00010) begin failures++; $display("FAIL cin_result got=%b_%h exp=0_0010", cout, sum); end
      checks++;
      if (ct[5:0] !== 6'b000011) begin failures++; $display("FAIL cin_add_ci_trace got=%b exp=000011", ct[5:0]); end
      checks++;
      if (add_ci !== 1'b0) begin failures++; $display("FAIL cin_idle_add_ci got=%b exp=0", add_ci); end
   endtask

   task automatic test_start_while_busy();
      bit seen;
      @(negedge clk);
      start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0;
      @(negedge clk);                         // k=0
      start = 1'b0;
      @(negedge clk);                         // k=1, RUN
      start = 1'b1; op_a = 16'hAAAA;
      repeat (3) @(negedge clk);              // k=4, DONE
      checks++;
      if ({done, cout, sum} !== 18'h25555) begin
         failures++;
         $display("FAIL busy_start_result got done=%b cout=%b sum=%h exp done=1 cout=0 sum=5555", done, cout, sum);
      end
      @(negedge clk);                         // k=5, IDLE with start still high
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
      @(negedge clk);                         // k=6, new start taken at edge 6
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_start_accept got=%b exp=1", busy); end
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b1) begin failures++; $display("FAIL busy_start_second_done got=%b exp=1", seen); end
      checks++;
      if ({cout, sum} !== 17'h0EDCB) begin failures++; $display("FAIL busy_start_second_result got=%b_%h exp=0_edcb", cout, sum); end
      $display("op a=aaaa b=4321 cin=0 (after ignored start) -> sum=%h cout=%b", sum, cout);
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int dk, dc, bc; logic [15:0] ct; bit to;
      @(negedge clk);
      start = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0;
      @(negedge clk);                         // k=0
      start = 1'b0;
      repeat (2) @(negedge clk);              // k=2, RUN idx 2
      checks++;
      if (add_a !== 4'h2) begin failures++; $display("FAIL midrst_idx2_add_a got=%h exp=2", add_a); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, sum, cout} !== 19'h0) begin
         failures++;
         $display("FAIL midrst_outputs got busy=%b done=%b sum=%h cout=%b exp all zero", busy, done, sum, cout);
      end
      checks++;
      if ({add_a, add_b, add_ci} !== 9'h0) begin failures++; $display("FAIL midrst_add_ports got a=%h b=%h ci=%b exp zero", add_a, add_b, add_ci); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset asserted mid-run and released");
      do_op(16'hFFFF, 16'h0001, 1'b1, dk, dc, bc, ct, to);
      checks++;
      if ({cout, sum} !== 17'h10001) begin failures++; $display("FAIL midrst_next_result got=%b_%h exp=1_0001", cout, sum); end
      checks++;
      if (dk !== 4) begin failures++; $display("FAIL midrst_next_done_cycle got=%0d exp=4", dk); end
   endtask

   task automatic test_single_nibble();
      int done_k; bit to; logic ci0;
      @(negedge clk);
      start1 = 1'b1; op_a1 = 4'hF; op_b1 = 4'h1; cin1 = 1'b1;
      @(negedge clk);                         // k=0, RUN idx 0
      start1 = 1'b0; op_a1 = 4'h0; op_b1 = 4'h0; cin1 = 1'b0;
      ci0 = add_ci1;
      done_k = -1; to = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         if (done1 && done_k < 0) done_k = k;
         if (!busy1) begin to = 1'b0; break; end
      end
      $display("op n1 a=f b=1 cin=1 -> sum=%h cout=%b done_k=%0d", sum1, cout1, done_k);
      checks++;
      if ({cout1, sum1} !== 5'h11) begin failures++; $display("FAIL n1_result got=%b_%h exp=1_1", cout1, sum1); end
      checks++;
      if (done_k !== 1) begin failures++; $display("FAIL n1_done_cycle got=%0d exp=1", done_k); end
      checks++;
      if (ci0 !== 1'b1) begin failures++; $display("FAIL n1_add_ci got=%b exp=1", ci0); end
      checks++;
      if (to !== 1'b0) begin failures++; $display("FAIL n1_timeout got=%b exp=0", to); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_carry_ripple();
      test_no_carry();
      test_cin_path();
      test_start_while_busy();
      test_reset_mid_run();
      test_single_nibble();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
